// File: rtl/aq_gemac_miim_slave.sv
// Clause 22 MDIO responder: oversamples MDC/MDIO on clk, decodes frames for
// its PHY address and serves a 32 x 16-bit register file shared with a local port.
module aq_gemac_miim_slave #(
  parameter logic [15:0] PHY_ID1      = 16'h0000,
  parameter logic [15:0] PHY_ID2      = 16'h0000,
  parameter int unsigned PREAMBLE_MIN = 32
) (
  input  logic        rst_n,
  input  logic        clk,
  input  logic [4:0]  phy_address,
  input  logic        mdc,
  input  logic        mdio_in,
  output logic        mdio_out,
  output logic        mdio_out_enable,
  input  logic        reg_we,
  input  logic [4:0]  reg_addr,
  input  logic [15:0] reg_wdata,
  output logic [15:0] reg_rdata,
  output logic        wr_strobe,
  output logic [4:0]  wr_reg_addr,
  output logic [15:0] wr_data,
  output logic        busy
);

  typedef enum logic [2:0] {S_IDLE, S_ST, S_OP, S_PHYAD, S_REGAD, S_TA, S_DATA} state_t;

  localparam logic [5:0] PRE_MAX = 6'(PREAMBLE_MIN);

  logic        mdc_s1, mdc_s2, mdc_d, rise;
  logic        mdio_s1, mdio_s2, bit_in;
  state_t      state;
  logic [5:0]  pre_cnt;
  logic [3:0]  bit_cnt;
  logic        is_read;
  logic [15:0] shift;
  logic [4:0]  regad;
  logic [15:0] regs [32];

  function automatic logic read_only(input logic [4:0] a);
    return (a == 5'd2) || (a == 5'd3);
  endfunction

  function automatic logic [15:0] read_reg(input logic [4:0] a);
    logic [15:0] v;
    v = regs[a];
    if (a == 5'd2) v = PHY_ID1;
    if (a == 5'd3) v = PHY_ID2;
    return v;
  endfunction

  // Register 0 bit 15 is a self-clearing control bit and never stays set.
  function automatic logic [15:0] store_val(input logic [4:0] a, input logic [15:0] d);
    return (a == 5'd0) ? {1'b0, d[14:0]} : d;
  endfunction

  // MDIO is delayed alongside the MDC edge detector so bit_in lines up with rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdc_s1  <= 1'b0;
      mdc_s2  <= 1'b0;
      mdc_d   <= 1'b0;
      rise    <= 1'b0;
      mdio_s1 <= 1'b0;
      mdio_s2 <= 1'b0;
      bit_in  <= 1'b0;
    end else begin
      mdc_s1  <= mdc;
      mdc_s2  <= mdc_s1;
      mdc_d   <= mdc_s2;
      rise    <= mdc_s2 & ~mdc_d;
      mdio_s1 <= mdio_in;
      mdio_s2 <= mdio_s1;
      bit_in  <= mdio_s2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      pre_cnt         <= '0;
      bit_cnt         <= '0;
      is_read         <= 1'b0;
      shift           <= '0;
      regad           <= '0;
      mdio_out        <= 1'b1;
      mdio_out_enable <= 1'b0;
      wr_strobe       <= 1'b0;
      wr_reg_addr     <= '0;
      wr_data         <= '0;
      busy            <= 1'b0;
    end else begin
      wr_strobe <= 1'b0;
      if (rise) begin
        unique case (state)
          S_IDLE: begin
            if (bit_in) begin
              if (pre_cnt != PRE_MAX) pre_cnt <= pre_cnt + 6'd1;
            end else begin
              pre_cnt <= '0;
              if (pre_cnt == PRE_MAX) begin
                state <= S_ST;
                busy  <= 1'b1;
              end
            end
          end
          S_ST: begin
            bit_cnt <= '0;
            if (bit_in) state <= S_OP;
            else begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end
          end
          S_OP: begin
            shift <= {shift[14:0], bit_in};
            if (bit_cnt == 4'd0) bit_cnt <= 4'd1;
            else begin
              bit_cnt <= '0;
              // 10 is read, 01 is write; equal bits are invalid opcodes.
              if (shift[0] != bit_in) begin
                is_read <= shift[0];
                state   <= S_PHYAD;
              end else begin
                state <= S_IDLE;
                busy  <= 1'b0;
              end
            end
          end
          S_PHYAD: begin
            shift <= {shift[14:0], bit_in};
            if (bit_cnt == 4'd4) begin
              bit_cnt <= '0;
              if ({shift[3:0], bit_in} == phy_address) state <= S_REGAD;
              else begin
                state <= S_IDLE;
                busy  <= 1'b0;
              end
            end else bit_cnt <= bit_cnt + 4'd1;
          end
          S_REGAD: begin
            shift <= {shift[14:0], bit_in};
            if (bit_cnt == 4'd4) begin
              bit_cnt <= '0;
              regad   <= {shift[3:0], bit_in};
              state   <= S_TA;
              if (is_read) shift <= read_reg({shift[3:0], bit_in});
            end else bit_cnt <= bit_cnt + 4'd1;
          end
          S_TA: begin
            if (bit_cnt == 4'd0) begin
              bit_cnt <= 4'd1;
              if (is_read) begin
                mdio_out_enable <= 1'b1;
                mdio_out        <= 1'b0;
              end
            end else begin
              bit_cnt <= '0;
              state   <= S_DATA;
              if (is_read) begin
                mdio_out <= shift[15];
                shift    <= {shift[14:0], 1'b0};
              end
            end
          end
          S_DATA: begin
            bit_cnt <= bit_cnt + 4'd1;
            if (is_read) begin
              if (bit_cnt == 4'd15) begin
                mdio_out_enable <= 1'b0;
                mdio_out        <= 1'b1;
                state           <= S_IDLE;
                busy            <= 1'b0;
              end else begin
                mdio_out <= shift[15];
                shift    <= {shift[14:0], 1'b0};
              end
            end else begin
              shift <= {shift[14:0], bit_in};
              if (bit_cnt == 4'd15) begin
                wr_strobe   <= 1'b1;
                wr_reg_addr <= regad;
                wr_data     <= {shift[14:0], bit_in};
                state       <= S_IDLE;
                busy        <= 1'b0;
              end
            end
          end
          default: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  // The MDIO commit lands on the cycle wr_strobe is high and beats a local write to the same address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
      reg_rdata <= '0;
    end else begin
      if (wr_strobe && !read_only(wr_reg_addr))
        regs[wr_reg_addr] <= store_val(wr_reg_addr, wr_data);
      if (reg_we && !read_only(reg_addr) && !(wr_strobe && (wr_reg_addr == reg_addr)))
        regs[reg_addr] <= store_val(reg_addr, reg_wdata);
      reg_rdata <= read_reg(reg_addr);
    end
  end

endmodule

// File: tb/tb_aq_gemac_miim_slave.sv
// Directed bench for aq_gemac_miim_slave: drives Clause 22 frames on MDC/MDIO
// and checks commits and read data against a queue-based scoreboard.
module tb_aq_gemac_miim_slave;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  phy_address = 5'd1;
  logic        mdc = 1'b0;
  logic        mdio_in = 1'b1;
  logic        mdio_out, mdio_out_enable;
  logic        reg_we = 1'b0;
  logic [4:0]  reg_addr = '0;
  logic [15:0] reg_wdata = '0;
  logic [15:0] reg_rdata;
  logic        wr_strobe;
  logic [4:0]  wr_reg_addr;
  logic [15:0] wr_data;
  logic        busy;

  aq_gemac_miim_slave #(
    .PHY_ID1(16'h0141),
    .PHY_ID2(16'h0CC2),
    .PREAMBLE_MIN(32)
  ) dut (
    .rst_n(rst_n), .clk(clk), .phy_address(phy_address),
    .mdc(mdc), .mdio_in(mdio_in), .mdio_out(mdio_out), .mdio_out_enable(mdio_out_enable),
    .reg_we(reg_we), .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_rdata(reg_rdata),
    .wr_strobe(wr_strobe), .wr_reg_addr(wr_reg_addr), .wr_data(wr_data), .busy(busy)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] wr_q [$];
  logic [15:0] rd_q [$];
  logic [15:0] model [32];
  int          strobe_cycles = 0;
  int          oe_cycles = 0;
  logic [4:0]  cap_addr = '0;
  logic [15:0] cap_data = '0;
  logic        s_out, s_oe, s_busy;

  always @(negedge clk) begin
    if (wr_strobe) begin
      strobe_cycles++;
      cap_addr = wr_reg_addr;
      cap_data = wr_data;
    end
    if (mdio_out_enable) oe_cycles++;
  end

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) model[i] = 16'h0000;
    model[2] = 16'h0141;
    model[3] = 16'h0CC2;
  endtask

  task automatic model_write(input logic [4:0] a, input logic [15:0] d);
    if (a != 5'd2 && a != 5'd3) model[a] = (a == 5'd0) ? (d & 16'h7FFF) : d;
  endtask

  // One MDC period of 10 clk; outputs are sampled just before the rising edge.
  task automatic mdio_cycle(input logic b);
    mdio_in = b;
    mdc = 1'b0;
    repeat (5) @(negedge clk);
    s_out = mdio_out;
    s_oe = mdio_out_enable;
    s_busy = busy;
    mdc = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic send_bits(input logic [15:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) mdio_cycle(v[i]);
  endtask

  task automatic header(input int pre, input logic [1:0] op, input logic [4:0] pa, input logic [4:0] ra);
    repeat (pre) mdio_cycle(1'b1);
    mdio_cycle(1'b0);
    mdio_cycle(1'b1);
    send_bits({14'd0, op}, 2);
    send_bits({11'd0, pa}, 5);
    send_bits({11'd0, ra}, 5);
  endtask

  task automatic local_write(input logic [4:0] a, input logic [15:0] d);
    reg_we = 1'b1;
    reg_addr = a;
    reg_wdata = d;
    @(negedge clk);
    reg_we = 1'b0;
    model_write(a, d);
  endtask

  task automatic local_read(input logic [4:0] a, input string tag);
    reg_addr = a;
    repeat (2) @(negedge clk);
    check_output(tag, {16'd0, reg_rdata}, {16'd0, model[a]});
  endtask

  task automatic mdio_write(input int pre, input logic [4:0] pa, input logic [4:0] ra,
                            input logic [15:0] d, input bit collide, input logic [15:0] local_d);
    int          s0;
    bit          accept;
    logic [31:0] exp;
    s0 = strobe_cycles;
    accept = (pre >= 32) && (pa == phy_address);
    if (accept) wr_q.push_back({11'd0, ra, d});
    header(pre, 2'b01, pa, ra);
    mdio_cycle(1'b1);
    mdio_cycle(1'b0);
    send_bits({1'b0, d[15:1]}, 15);
    mdio_in = d[0];
    mdc = 1'b0;
    repeat (5) @(negedge clk);
    mdc = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      reg_we = collide && wr_strobe;
      reg_addr = ra;
      reg_wdata = local_d;
    end
    reg_we = 1'b0;
    mdio_cycle(1'b1);
    mdio_cycle(1'b1);
    if (accept) model_write(ra, d);
    check_output("wr_strobe_cycles", strobe_cycles - s0, accept ? 1 : 0);
    if (accept) begin
      exp = wr_q.pop_front();
      check_output("wr_reg_addr", {27'd0, cap_addr}, {27'd0, exp[20:16]});
      check_output("wr_data", {16'd0, cap_data}, {16'd0, exp[15:0]});
    end
  endtask

  task automatic mdio_read(input int pre, input logic [4:0] pa, input logic [4:0] ra, input int abort_idx);
    int          oe0;
    bit          accept;
    logic [15:0] got, exp;
    logic        ta_z, ta_oe, ta_out, oe_all, busy_mid;
    oe0 = oe_cycles;
    accept = (pre >= 32) && (pa == phy_address);
    got = '0;
    oe_all = 1'b1;
    ta_z = 1'b0; ta_oe = 1'b0; ta_out = 1'b0; busy_mid = 1'b0;
    if (accept) rd_q.push_back(model[ra]);
    header(pre, 2'b10, pa, ra);
    for (int i = 0; i < 18; i++) begin
      mdio_in = 1'b1;
      mdc = 1'b0;
      repeat (5) @(negedge clk);
      if (i == abort_idx) begin
        check_output("rd_oe_before_reset", {31'd0, mdio_out_enable}, 32'd1);
        #3 rst_n = 1'b0;
        #1;
        check_output("reset_oe_async", {31'd0, mdio_out_enable}, 32'd0);
        check_output("reset_out_async", {31'd0, mdio_out}, 32'd1);
        check_output("reset_busy_async", {31'd0, busy}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        void'(rd_q.pop_front());
        repeat (2) @(negedge clk);
        return;
      end
      if (i == 0) ta_z = mdio_out_enable;
      if (i == 1) begin
        ta_oe = mdio_out_enable;
        ta_out = mdio_out;
      end
      if (i >= 2) begin
        got = {got[14:0], mdio_out};
        oe_all = oe_all & mdio_out_enable;
      end
      if (i == 8) busy_mid = busy;
      mdc = 1'b1;
      repeat (5) @(negedge clk);
    end
    mdio_cycle(1'b1);
    if (accept) begin
      exp = rd_q.pop_front();
      check_output("rd_ta_z", {31'd0, ta_z}, 32'd0);
      check_output("rd_ta_oe", {31'd0, ta_oe}, 32'd1);
      check_output("rd_ta_zero", {31'd0, ta_out}, 32'd0);
      check_output("rd_data", {16'd0, got}, {16'd0, exp});
      check_output("rd_oe_held", {31'd0, oe_all}, 32'd1);
      check_output("rd_busy_mid", {31'd0, busy_mid}, 32'd1);
      check_output("rd_release_oe", {31'd0, s_oe}, 32'd0);
      check_output("rd_release_out", {31'd0, s_out}, 32'd1);
      check_output("rd_busy_after", {31'd0, s_busy}, 32'd0);
    end else begin
      check_output("rd_no_drive", oe_cycles - oe0, 32'd0);
    end
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    check_output("rst_mdio_out", {31'd0, mdio_out}, 32'd1);
    check_output("rst_oe", {31'd0, mdio_out_enable}, 32'd0);
    check_output("rst_wr_strobe", {31'd0, wr_strobe}, 32'd0);
    check_output("rst_wr_reg_addr", {27'd0, wr_reg_addr}, 32'd0);
    check_output("rst_wr_data", {16'd0, wr_data}, 32'd0);
    check_output("rst_reg_rdata", {16'd0, reg_rdata}, 32'd0);
    check_output("rst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    local_read(5'd2, "local_id1");
    local_read(5'd3, "local_id2");

    $display("[TB] write then read reg 4");
    mdio_write(32, 5'd1, 5'd4, 16'hA5C3, 1'b0, 16'h0);
    local_read(5'd4, "local_after_commit");
    mdio_read(32, 5'd1, 5'd4, -1);

    $display("[TB] read-only ID registers");
    mdio_write(32, 5'd1, 5'd2, 16'hFFFF, 1'b0, 16'h0);
    mdio_read(32, 5'd1, 5'd2, -1);
    mdio_read(32, 5'd1, 5'd3, -1);

    $display("[TB] address mismatch and short preamble");
    mdio_write(32, 5'd2, 5'd5, 16'h1234, 1'b0, 16'h0);
    mdio_read(32, 5'd2, 5'd4, -1);
    mdio_cycle(1'b0);
    mdio_write(31, 5'd1, 5'd5, 16'h1111, 1'b0, 16'h0);
    local_read(5'd5, "short_preamble_ignored");

    $display("[TB] invalid opcode then valid frame");
    repeat (32) mdio_cycle(1'b1);
    mdio_cycle(1'b0);
    mdio_cycle(1'b1);
    mdio_cycle(1'b1);
    check_output("busy_after_st", {31'd0, s_busy}, 32'd1);
    mdio_cycle(1'b1);
    check_output("busy_in_op", {31'd0, s_busy}, 32'd1);
    mdio_cycle(1'b1);
    check_output("busy_after_bad_op", {31'd0, s_busy}, 32'd0);
    mdio_write(32, 5'd1, 5'd6, 16'hBEEF, 1'b0, 16'h0);
    mdio_read(32, 5'd1, 5'd6, -1);

    $display("[TB] local port access");
    local_write(5'd9, 16'hCAFE);
    mdio_read(32, 5'd1, 5'd9, -1);
    local_write(5'd3, 16'h0000);
    local_read(5'd3, "local_ro_write");

    $display("[TB] collision and self-clearing bit");
    mdio_write(32, 5'd1, 5'd7, 16'h1234, 1'b1, 16'h5678);
    local_read(5'd7, "collision_rdata");
    mdio_write(32, 5'd1, 5'd0, 16'h8000, 1'b0, 16'h0);
    mdio_read(32, 5'd1, 5'd0, -1);

    $display("[TB] reset during read");
    mdio_read(32, 5'd1, 5'd2, 9);
    mdio_read(32, 5'd1, 5'd2, -1);
    mdio_read(32, 5'd1, 5'd4, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
